// File: rtl/hex_word_loader_pkg.sv
// hex_loader_pkg: ASCII constants, FSM states and the byte classifier
// shared by the hex text loader and its character decoder.
package hex_loader_pkg;

   localparam logic [7:0] CR    = 8'h0D;
   localparam logic [7:0] LF    = 8'h0A;
   localparam logic [7:0] SP    = 8'h20;
   localparam logic [7:0] END_G = 8'h47;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
      ERR,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      CL_HEX,
      CL_SEP,
      CL_END,
      CL_BAD
   } char_class_t;

   typedef struct packed {
      char_class_t cls;
      logic [3:0]  nib;
   } char_info_t;

   // Letters map via low nibble + 9: 'A'/'a' carry low nibble 1 -> 10.
   function automatic char_info_t ascii_class(input logic [7:0] ch);
      char_info_t r;
      r.cls = CL_BAD;
      r.nib = 4'h0;
      unique case (1'b1)
         (ch >= 8'h30 && ch <= 8'h39): begin
            r.cls = CL_HEX;
            r.nib = ch[3:0];
         end
         (ch >= 8'h41 && ch <= 8'h46),
         (ch >= 8'h61 && ch <= 8'h66): begin
            r.cls = CL_HEX;
            r.nib = ch[3:0] + 4'd9;
         end
         (ch == SP || ch == CR || ch == LF): r.cls = CL_SEP;
         (ch == END_G): r.cls = CL_END;
         default: r.cls = CL_BAD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/hex_word_loader_if.sv
// hex_word_loader_if: uart rx/tx handshakes, imem write port and status.
// slave = loader side, master = environment side.
interface hex_word_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        rx_dout;
   logic              rx_rdy;
   logic              rx_rdy_clr;
   logic [7:0]        tx_din;
   logic              tx_wr_en;
   logic              tx_busy;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   word_count;
   logic              full;
   logic              err;
   logic              done;

   modport slave (
      input  rx_dout, rx_rdy, tx_busy,
      output rx_rdy_clr, tx_din, tx_wr_en,
      output mem_we, mem_addr, mem_wdata,
      output word_count, full, err, done
   );

   modport master (
      output rx_dout, rx_rdy, tx_busy,
      input  rx_rdy_clr, tx_din, tx_wr_en,
      input  mem_we, mem_addr, mem_wdata,
      input  word_count, full, err, done
   );
endinterface

// File: rtl/hex_word_loader_decode.sv
// hex_char_decode: combinational byte classifier feeding the loader FSM.
// Exactly one of is_hex/is_sep/is_end is set, or none for a bad byte.
module hex_char_decode
   import hex_loader_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_hex,
   output logic       is_sep,
   output logic       is_end,
   output logic [3:0] nib
);
   char_info_t info;

   assign info   = ascii_class(ch);
   assign is_hex = (info.cls == CL_HEX);
   assign is_sep = (info.cls == CL_SEP);
   assign is_end = (info.cls == CL_END);
   assign nib    = info.nib;
endmodule

// File: rtl/hex_word_loader.sv
// hex_word_loader: parses ASCII hex from the uart into 32-bit imem words,
// echoing each accepted byte; flags bad input, overflow and 'G' end-of-load.
module hex_word_loader
   import hex_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter bit ECHO   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   hex_word_loader_if.slave bus
);
   state_t state, state_nxt;

   logic [7:0]        byte_q;
   logic              clr_q;
   logic              wr_q;
   logic [2:0]        nib_cnt;
   logic [31:0]       wdata;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_inc;
   logic              full_q;
   logic              err_q;
   logic              done_q;

   logic       is_hex;
   logic       is_sep;
   logic       is_end;
   logic [3:0] nib;
   logic       accept;
   logic       load_en;
   logic       shift_en;

   hex_char_decode u_dec (
      .ch     (byte_q),
      .is_hex (is_hex),
      .is_sep (is_sep),
      .is_end (is_end),
      .nib    (nib)
   );

   // Byte is latched on accept and acted on while rx_rdy_clr is high.
   assign accept = bus.rx_rdy & ~bus.tx_busy & ~clr_q
                 & (state != WRITE);
   assign count_inc = count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_en   = 1'b0;
      shift_en  = 1'b0;
      if (clr_q) begin
         unique case (state)
            IDLE: begin
               if (is_hex) begin
                  load_en   = 1'b1;
                  state_nxt = COLLECT;
               end else if (is_end) begin
                  state_nxt = DONE;
               end else if (!is_sep) begin
                  state_nxt = ERR;
               end
            end
            COLLECT: begin
               if (is_hex) begin
                  shift_en = 1'b1;
                  if (nib_cnt == 3'd7)
                     state_nxt = full_q ? ERR : WRITE;
               end else begin
                  state_nxt = ERR;
               end
            end
            ERR: if (byte_q == LF) state_nxt = IDLE;
            default: state_nxt = state;
         endcase
      end
      if (state == WRITE) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_q  <= '0;
         clr_q   <= 1'b0;
         wr_q    <= 1'b0;
         nib_cnt <= '0;
         wdata   <= '0;
         addr    <= '0;
         count   <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         clr_q <= accept;
         wr_q  <= accept & ECHO;
         if (accept) byte_q <= bus.rx_dout;
         if (load_en) begin
            wdata   <= {28'd0, nib};
            nib_cnt <= 3'd1;
         end else if (shift_en) begin
            wdata   <= {wdata[27:0], nib};
            nib_cnt <= nib_cnt + 3'd1;
         end
         if (state_nxt != COLLECT) nib_cnt <= '0;
         if (state == WRITE) begin
            addr <= addr + 1'b1;
            if (!count[ADDR_W]) begin
               count  <= count_inc;
               full_q <= count_inc[ADDR_W];
            end
         end
         err_q  <= err_q  | (state_nxt == ERR);
         done_q <= done_q | (state_nxt == DONE);
      end
   end

   assign bus.rx_rdy_clr = clr_q;
   assign bus.tx_din     = byte_q;
   assign bus.tx_wr_en   = wr_q;
   assign bus.mem_we     = (state == WRITE);
   assign bus.mem_addr   = addr;
   assign bus.mem_wdata  = wdata;
   assign bus.word_count = count;
   assign bus.full       = full_q;
   assign bus.err        = err_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_hex_word_loader.sv
// tb_hex_word_loader: table vectors, corner sequences and random token
// streams checked against a queue-based model of the loader.
module tb_hex_word_loader;
   localparam int AW  = 2;
   localparam int CAP = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_clr_cyc = 0;
   bit   prev_clr = 1'b0;

   logic [63:0] dut_wr[$];
   logic [63:0] exp_wr[$];
   logic [7:0]  echo_q[$];
   logic [7:0]  sent_q[$];

   bit m_err, m_done, m_skip;
   int m_cnt;
   int m_nibs[$];

   typedef struct {
      string       s;
      bit          do_rst;
      int          n_wr;
      logic [31:0] last_data;
      int          last_addr;
      bit          e_err;
      bit          e_done;
      int          e_cnt;
      bit          e_full;
   } vec_t;

   vec_t vecs[8];

   hex_word_loader_if #(.ADDR_W(AW)) bus ();

   hex_word_loader #(.ADDR_W(AW), .ECHO(1'b1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.rx_rdy_clr || bus.tx_wr_en) begin
         checks++;
         if (bus.rx_rdy_clr !== bus.tx_wr_en ||
             (bus.rx_rdy_clr && prev_clr)) begin
            errors++;
            $display("FAIL pulse clr=%0b wr_en=%0b prev_clr=%0b",
                     bus.rx_rdy_clr, bus.tx_wr_en, prev_clr);
         end
      end
      if (bus.tx_wr_en) echo_q.push_back(bus.tx_din);
      if (bus.rx_rdy_clr) last_clr_cyc = cyc;
      if (bus.mem_we) begin
         dut_wr.push_back({30'd0, bus.mem_addr, bus.mem_wdata});
         checks++;
         if (cyc - last_clr_cyc != 1) begin
            errors++;
            $display("FAIL latency got %0d want 1",
                     cyc - last_clr_cyc);
         end
      end
      prev_clr = bus.rx_rdy_clr;
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic int hexval(input logic [7:0] b);
      if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
      if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
      if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
      return -1;
   endfunction

   task automatic model_byte(input logic [7:0] b);
      int v;
      logic [31:0] w;
      v = hexval(b);
      if (m_done) return;
      if (m_skip) begin
         if (b == 8'h0A) m_skip = 1'b0;
         return;
      end
      if (v >= 0) begin
         m_nibs.push_back(v);
         if (m_nibs.size() == 8) begin
            w = '0;
            foreach (m_nibs[i]) w = (w << 4) | 32'(m_nibs[i]);
            m_nibs.delete();
            if (m_cnt == CAP) begin
               m_err  = 1'b1;
               m_skip = 1'b1;
            end else begin
               exp_wr.push_back({32'(m_cnt), w});
               m_cnt++;
            end
         end
      end else if (m_nibs.size() > 0) begin
         m_nibs.delete();
         m_err  = 1'b1;
         m_skip = 1'b1;
      end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
         m_cnt = m_cnt;
      end else if (b == 8'h47) begin
         m_done = 1'b1;
      end else begin
         m_err  = 1'b1;
         m_skip = 1'b1;
      end
   endtask

   task automatic clear_all();
      dut_wr.delete();
      exp_wr.delete();
      echo_q.delete();
      sent_q.delete();
      m_nibs.delete();
      m_err  = 1'b0;
      m_done = 1'b0;
      m_skip = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.rx_rdy  = 1'b0;
      bus.tx_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_all();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      bus.rx_dout = b;
      bus.rx_rdy  = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
         bus.tx_busy = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         bus.tx_busy = 1'b0;
      end
      n = 0;
      while (!bus.rx_rdy_clr && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rx_rdy_clr) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout byte %0h got no rx_rdy_clr", b);
      end
      bus.rx_rdy = 1'b0;
      sent_q.push_back(b);
      model_byte(b);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic check_state(input string tag);
      int bad;
      check({tag, " n_wr"}, 64'(dut_wr.size()), 64'(exp_wr.size()));
      bad = 0;
      for (int i = 0; i < dut_wr.size() && i < exp_wr.size(); i++)
         if (dut_wr[i] !== exp_wr[i]) bad++;
      check({tag, " wr_mismatches"}, 64'(bad), 64'd0);
      bad = (echo_q.size() != sent_q.size()) ? 1 : 0;
      for (int i = 0; i < echo_q.size() && i < sent_q.size(); i++)
         if (echo_q[i] !== sent_q[i]) bad++;
      check({tag, " echo_mismatches"}, 64'(bad), 64'd0);
      check({tag, " err"}, 64'(bus.err), 64'(m_err));
      check({tag, " done"}, 64'(bus.done), 64'(m_done));
      check({tag, " count"}, 64'(bus.word_count), 64'(m_cnt));
      check({tag, " full"}, 64'(bus.full), 64'(m_cnt == CAP));
      check({tag, " addr"}, 64'(bus.mem_addr), 64'(m_cnt % CAP));
   endtask

   task automatic send_token();
      int r;
      int k;
      logic [7:0] c;
      logic [7:0] seps[3];
      seps[0] = 8'h20;
      seps[1] = 8'h0D;
      seps[2] = 8'h0A;
      r = $urandom_range(0, 19);
      if (r <= 15) begin
         k = (r <= 13) ? 8 : $urandom_range(1, 7);
         for (int i = 0; i < k; i++) begin
            c = 8'($urandom_range(0, 15));
            if (c < 10) c = c + 8'h30;
            else c = c - 8'd10 + ($urandom_range(0, 1) ? 8'h41 : 8'h61);
            send_byte(c);
         end
         send_byte(seps[$urandom_range(0, 2)]);
      end else if (r == 16) begin
         send_byte(8'h5A);
      end else if (r == 17) begin
         send_byte(8'h47);
      end else begin
         send_byte(8'h0A);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int n;
      vecs[0] = '{"DEADBEEF\n", 1, 1, 32'hDEADBEEF, 0, 0, 0, 1, 0};
      vecs[1] = '{"12345678 9abcdef0\r\n", 1, 2, 32'h9ABCDEF0,
                  1, 0, 0, 2, 0};
      vecs[2] = '{"12Z\n00000001\n", 1, 1, 32'h00000001,
                  0, 1, 0, 1, 0};
      vecs[3] = '{"1234\n", 1, 0, 32'h0, 0, 1, 0, 0, 0};
      vecs[4] = '{"G", 0, 0, 32'h0, 0, 1, 0, 0, 0};
      vecs[5] = '{"\nG", 0, 0, 32'h0, 0, 1, 1, 0, 0};
      vecs[6] = '{"11111111", 0, 0, 32'h0, 0, 1, 1, 0, 0};
      vecs[7] = '{"00000001 00000002 00000003\n00000004 00000005\n",
                  1, 4, 32'h00000004, 3, 1, 0, 4, 1};

      bus.rx_dout = 8'h00;
      bus.rx_rdy  = 1'b0;
      bus.tx_busy = 1'b0;
      do_reset();
      #1;
      check("rst rx_rdy_clr", 64'(bus.rx_rdy_clr), 64'd0);
      check("rst tx_wr_en", 64'(bus.tx_wr_en), 64'd0);
      check("rst tx_din", 64'(bus.tx_din), 64'd0);
      check("rst mem_we", 64'(bus.mem_we), 64'd0);
      check("rst mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check("rst word_count", 64'(bus.word_count), 64'd0);
      check("rst flags", {61'd0, bus.full, bus.err, bus.done}, 64'd0);

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].do_rst) begin
            do_reset();
            #1;
            check($sformatf("v%0d rst_outputs", v),
                  {bus.mem_wdata, 29'(bus.word_count), bus.full,
                   bus.err, bus.done},
                  64'd0);
         end else begin
            echo_q.delete();
            sent_q.delete();
         end
         send_str(vecs[v].s);
         repeat (4) @(negedge clk);
         check($sformatf("v%0d n_wr", v), 64'(dut_wr.size()),
               64'(vecs[v].n_wr));
         if (vecs[v].n_wr > 0 && dut_wr.size() > 0)
            check($sformatf("v%0d last_wr", v), dut_wr[$],
                  {32'(vecs[v].last_addr), vecs[v].last_data});
         check($sformatf("v%0d err", v), 64'(bus.err),
               64'(vecs[v].e_err));
         check($sformatf("v%0d done", v), 64'(bus.done),
               64'(vecs[v].e_done));
         check($sformatf("v%0d count", v), 64'(bus.word_count),
               64'(vecs[v].e_cnt));
         check($sformatf("v%0d full", v), 64'(bus.full),
               64'(vecs[v].e_full));
         check_state($sformatf("v%0d model", v));
      end

      // tx_busy stalls acceptance for as long as it is held
      do_reset();
      bus.tx_busy = 1'b1;
      bus.rx_dout = 8'h41;
      bus.rx_rdy  = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rx_rdy_clr || bus.tx_wr_en) bad++;
      end
      check("busy_block", 64'(bad), 64'd0);
      bus.tx_busy = 1'b0;
      n = 0;
      while (!bus.rx_rdy_clr && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("busy_release", 64'(bus.rx_rdy_clr), 64'd1);
      bus.rx_rdy = 1'b0;
      sent_q.push_back(8'h41);
      model_byte(8'h41);
      send_str("BC");
      do_reset();
      send_str("00000002");
      repeat (4) @(negedge clk);
      check("abort_word n_wr", 64'(dut_wr.size()), 64'd1);
      if (dut_wr.size() > 0)
         check("abort_word wr", dut_wr[0], {32'd0, 32'h00000002});
      check_state("abort_word model");

      // reset on the cycle the 8th nibble would move to WRITE
      do_reset();
      send_str("0000000");
      send_byte(8'h39);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_mid_write n_wr", 64'(dut_wr.size()), 64'd0);
      check("rst_mid_write count", 64'(bus.word_count), 64'd0);
      rst = 1'b0;
      clear_all();
      send_str("0000000A\n");
      repeat (4) @(negedge clk);
      check_state("after_mid_write");

      for (int c = 0; c < 40; c++) begin
         if (c == 0 || $urandom_range(0, 3) == 0) do_reset();
         repeat ($urandom_range(2, 6)) send_token();
         repeat (4) @(negedge clk);
         check_state($sformatf("rand%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
